// File: rtl/gf_result_demux.sv
// Write-back router for the GF(2^8) inversion datapath: buffers one multiplier
// product and steers it into operand register q0..q3 selected by its dest tag.
module gf_result_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             init_we,
    input  logic [WIDTH-1:0] init_data,
    input  logic             hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             in_last,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [3:0]       q_valid,
    output logic [7:0]       wr_cnt,
    output logic             busy,
    output logic             done
);

    // state  | meaning
    // IDLE   | accept init loads, wait for start
    // ACTIVE | accept products, write back from the one-entry buffer
    // DONE   | last product written; one-cycle done pulse
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q [4];
    logic [3:0]       r_q_valid;
    logic [7:0]       r_wr_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pend_v;
    logic [WIDTH-1:0] r_pend_data;
    logic [1:0]       r_pend_dest;
    logic             r_pend_last;

    logic w_in_ready;
    logic w_accept;
    logic w_write;

    // Once the last product is buffered nothing more may enter this run.
    assign w_in_ready = (r_state == S_ACTIVE) && !(r_pend_v && r_pend_last)
                        && (!r_pend_v || !hold);
    assign w_accept   = in_valid && w_in_ready;
    assign w_write    = (r_state == S_ACTIVE) && r_pend_v && !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_q[0]      <= '0;
            r_q[1]      <= '0;
            r_q[2]      <= '0;
            r_q[3]      <= '0;
            r_q_valid   <= '0;
            r_wr_cnt    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_data <= '0;
            r_pend_dest <= '0;
            r_pend_last <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (init_we) begin
                        r_q[0]       <= init_data;
                        r_q_valid[0] <= 1'b1;
                    end
                    if (start) begin
                        r_q_valid[3:1] <= '0;
                        r_wr_cnt       <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_write) begin
                        r_q[r_pend_dest]       <= r_pend_data;
                        r_q_valid[r_pend_dest] <= 1'b1;
                        if (r_wr_cnt != 8'hFF)
                            r_wr_cnt <= r_wr_cnt + 8'd1;
                        if (r_pend_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    if (w_accept) begin
                        r_pend_v    <= 1'b1;
                        r_pend_data <= in_data;
                        r_pend_dest <= in_dest;
                        r_pend_last <= in_last;
                    end else if (w_write) begin
                        r_pend_v <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_pend_v <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_pend_v <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign q0       = r_q[0];
    assign q1       = r_q[1];
    assign q2       = r_q[2];
    assign q3       = r_q[3];
    assign q_valid  = r_q_valid;
    assign wr_cnt   = r_wr_cnt;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_gf_result_demux.sv
// Directed bench for gf_result_demux: a vector table for init/stream/hold/overwrite/last,
// plus hand sequences for mid-run reset and write-count saturation.
module tb_gf_result_demux;

    logic       clk;
    logic       rst;
    logic       start;
    logic       init_we;
    logic [7:0] init_data;
    logic       hold;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       in_last;
    logic [7:0] q0, q1, q2, q3;
    logic [3:0] q_valid;
    logic [7:0] wr_cnt;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    gf_result_demux #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .init_we(init_we), .init_data(init_data),
        .hold(hold), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .in_last(in_last), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q_valid(q_valid), .wr_cnt(wr_cnt), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       init_we;
        logic [7:0] init_data;
        logic       hold;
        logic       in_valid;
        logic [7:0] in_data;
        logic [1:0] in_dest;
        logic       in_last;
        logic       e_ready;
        logic [7:0] e_q0, e_q1, e_q2, e_q3;
        logic [3:0] e_qv;
        logic [7:0] e_cnt;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] eqv,
                            input logic [7:0] ecnt, input logic eb, input logic ed);
        chk({tag, ".q0"}, 32'(q0), 32'(e0));
        chk({tag, ".q1"}, 32'(q1), 32'(e1));
        chk({tag, ".q2"}, 32'(q2), 32'(e2));
        chk({tag, ".q3"}, 32'(q3), 32'(e3));
        chk({tag, ".q_valid"}, 32'(q_valid), 32'(eqv));
        chk({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(ecnt));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic idle_inputs();
        start = 0; init_we = 0; init_data = 8'h00; hold = 0;
        in_valid = 0; in_data = 8'h00; in_dest = 2'd0; in_last = 0;
    endtask

    initial begin
        bit seen_done;

        //          st iw idat  h  v  data  d  l  rdy  q0     q1     q2     q3     qv       cnt   b  d
        vecs[0]  = '{0, 1, 8'h53, 0, 0, 8'h00, 0, 0, 0, 8'h53, 8'h00, 8'h00, 8'h00, 4'b0001, 8'd0, 0, 0};
        vecs[1]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h53, 8'h00, 8'h00, 8'h00, 4'b0001, 8'd0, 1, 0};
        vecs[2]  = '{0, 0, 8'h00, 0, 1, 8'hCA, 1, 0, 1, 8'h53, 8'h00, 8'h00, 8'h00, 4'b0001, 8'd0, 1, 0};
        vecs[3]  = '{0, 0, 8'h00, 0, 1, 8'h1B, 2, 0, 1, 8'h53, 8'hCA, 8'h00, 8'h00, 4'b0011, 8'd1, 1, 0};
        vecs[4]  = '{0, 0, 8'h00, 0, 1, 8'hFF, 3, 1, 1, 8'h53, 8'hCA, 8'h1B, 8'h00, 4'b0111, 8'd2, 1, 0};
        vecs[5]  = '{0, 0, 8'h00, 0, 1, 8'h77, 0, 0, 0, 8'h53, 8'hCA, 8'h1B, 8'hFF, 4'b1111, 8'd3, 1, 1};
        vecs[6]  = '{0, 0, 8'h00, 0, 1, 8'h77, 0, 0, 0, 8'h53, 8'hCA, 8'h1B, 8'hFF, 4'b1111, 8'd3, 0, 0};
        vecs[7]  = '{0, 0, 8'h00, 0, 1, 8'h77, 0, 0, 0, 8'h53, 8'hCA, 8'h1B, 8'hFF, 4'b1111, 8'd3, 0, 0};
        vecs[8]  = '{1, 1, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 8'h5A, 8'hCA, 8'h1B, 8'hFF, 4'b0001, 8'd0, 1, 0};
        vecs[9]  = '{0, 0, 8'h00, 1, 1, 8'h10, 2, 0, 1, 8'h5A, 8'hCA, 8'h1B, 8'hFF, 4'b0001, 8'd0, 1, 0};
        vecs[10] = '{0, 1, 8'h99, 1, 1, 8'h20, 2, 0, 0, 8'h5A, 8'hCA, 8'h1B, 8'hFF, 4'b0001, 8'd0, 1, 0};
        vecs[11] = '{0, 0, 8'h00, 1, 1, 8'h20, 2, 0, 0, 8'h5A, 8'hCA, 8'h1B, 8'hFF, 4'b0001, 8'd0, 1, 0};
        vecs[12] = '{0, 0, 8'h00, 1, 1, 8'h20, 2, 0, 0, 8'h5A, 8'hCA, 8'h1B, 8'hFF, 4'b0001, 8'd0, 1, 0};
        vecs[13] = '{0, 0, 8'h00, 0, 1, 8'h20, 2, 0, 1, 8'h5A, 8'hCA, 8'h10, 8'hFF, 4'b0101, 8'd1, 1, 0};
        vecs[14] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h5A, 8'hCA, 8'h20, 8'hFF, 4'b0101, 8'd2, 1, 0};
        vecs[15] = '{0, 0, 8'h00, 0, 1, 8'hAA, 0, 1, 1, 8'h5A, 8'hCA, 8'h20, 8'hFF, 4'b0101, 8'd2, 1, 0};
        vecs[16] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h5A, 8'hCA, 8'h20, 8'hFF, 4'b0101, 8'd2, 1, 0};
        vecs[17] = '{0, 0, 8'h00, 0, 1, 8'h33, 1, 0, 0, 8'hAA, 8'hCA, 8'h20, 8'hFF, 4'b0101, 8'd3, 1, 1};
        vecs[18] = '{0, 0, 8'h00, 0, 1, 8'h33, 1, 0, 0, 8'hAA, 8'hCA, 8'h20, 8'hFF, 4'b0101, 8'd3, 0, 0};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk_outs("rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0, 1'b0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start; init_we = vecs[i].init_we; init_data = vecs[i].init_data;
            hold = vecs[i].hold; in_valid = vecs[i].in_valid; in_data = vecs[i].in_data;
            in_dest = vecs[i].in_dest; in_last = vecs[i].in_last;
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            chk_outs($sformatf("v%0d", i), vecs[i].e_q0, vecs[i].e_q1, vecs[i].e_q2, vecs[i].e_q3,
                     vecs[i].e_qv, vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_done);
        end

        // Reset in the middle of a run with a result stuck in the buffer.
        idle_inputs();
        start = 1;
        @(posedge clk); #1;
        start = 0; hold = 1; in_valid = 1; in_data = 8'h77; in_dest = 2'd3;
        @(posedge clk); #1;
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("mrst.in_ready", 32'(in_ready), 32'd0);
        chk_outs("mrst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0, 1'b0, 1'b0);
        @(posedge clk); #4 rst = 1'b0;
        hold = 0; init_we = 1; init_data = 8'h53;
        @(posedge clk); #1;
        init_we = 0;
        chk_outs("init", 8'h53, 8'h00, 8'h00, 8'h00, 4'b0001, 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("init.q3_nowrite", 32'(q3), 32'h00);

        // Saturation: 300 back-to-back non-last writes.
        start = 1;
        @(posedge clk); #1;
        start = 0; in_valid = 1; in_last = 0;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i); in_dest = 2'(i);
            @(posedge clk); #1;
            if (i == 254) chk("sat.cnt254", 32'(wr_cnt), 32'd254);
            if (i == 255) chk("sat.cnt255", 32'(wr_cnt), 32'd255);
        end
        in_valid = 0;
        @(posedge clk); #1;
        chk("sat.cnt_final", 32'(wr_cnt), 32'd255);
        chk("sat.q3_last", 32'(q3), 32'h2B);
        in_valid = 1; in_last = 1; in_data = 8'hE1; in_dest = 2'd1;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
        seen_done = 0;
        for (int k = 0; k < 8 && !seen_done; k++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        chk("sat.done_seen", 32'(seen_done), 32'd1);
        chk("sat.cnt_after_last", 32'(wr_cnt), 32'd255);
        chk("sat.q1_last", 32'(q1), 32'hE1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gf_result_demux.md
# gf_result_demux

Write-back router for the GF(2^8) Itoh-Tsuji inversion datapath. It accepts each product from the field multiplier over a valid/ready handshake and steers it into one of four operand registers. Those registers feed the multiplicand-select mux on the multiplier inputs. It buffers one pending result, supports a hold stall while operands are being read, and signals completion when the result tagged as last has been written.

## Interface
Parameters:
- WIDTH, 8, field element width (GF(2^8))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  IDLE→ACTIVE request; ignored outside IDLE
- init_we  in  1  load init_data into q0 (IDLE only)
- init_data  in  WIDTH  initial element a
- hold  in  1  freezes register write-back (pending entry kept)
- in_valid  in  1  multiplier result valid
- in_ready  out  1  router can accept a result
- in_data  in  WIDTH  multiplier product
- in_dest  in  2  destination register index 0..3
- in_last  in  1  final product of the inversion
- q0, q1, q2, q3  out  WIDTH each  operand registers (to mux d0..d3)
- q_valid  out  4  per-register "written since start/init" flags
- wr_cnt  out  8  count of completed write-backs this run, saturating at 255
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last write

## Operation
- State machine states: IDLE, ACTIVE, DONE.
- **IDLE**
  - in_ready=0.
  - init_we: q0<=init_data and q_valid[0]<=1.
  - start: q_valid[3:1]<=0, wr_cnt<=0, go to ACTIVE. q_valid[0] is kept.
  - init_we and start in the same cycle: both take effect.
- **ACTIVE**
  - One-entry pending buffer: pend_v, pend_data, pend_dest, pend_last.
  - in_ready = !(pend_v && pend_last) && (!pend_v || !hold).
  - Accept (in_valid && in_ready): load the pending buffer and set pend_v.
  - Write (pend_v && !hold):
    - q[pend_dest]<=pend_data and q_valid[pend_dest]<=1.
    - wr_cnt<=wr_cnt+1, saturating at 255.
    - pend_v cleared, unless a new accept occurs in the same cycle.
    - If pend_last, go to DONE.
  - Accept and write in the same cycle is legal and gives full throughput: 1 result/cycle while hold=0.
  - Writes to the same dest simply overwrite.
  - init_we and start are ignored.
- **DONE**
  - done=1 for exactly this cycle, in_ready=0.
  - Next state is IDLE. q0..q3 and q_valid are retained for readout.
- Reset (any time, including mid-run):
  - q0..q3=0, q_valid=0, wr_cnt=0.
  - pend_v=0, in_ready=0, done=0, busy=0, state IDLE.
  - Any pending result is discarded.
- No arithmetic on data: values pass through unmodified, WIDTH bits.

## Timing
- Latency: accepted at edge N, visible on q[dest] after edge N+1 when hold=0 at N+1.
- Each hold cycle adds one cycle of latency.
- in_ready is combinational from state, pend_v, pend_last and hold. All other outputs are registered.
- Last result: accepted at edge N, written at N+1 (state→DONE), done high during cycle N+1→N+2, busy low from edge N+2.
- Once the last entry is pending, in_ready stays 0 until IDLE, so no result after last is accepted.
- hold high with pend_v=1 gives in_ready=0: back-pressure to the multiplier.
- hold high with pend_v=0 gives in_ready=1: one result can be buffered.

## Test plan
- **Reset/init:** assert rst mid-ACTIVE with pend_v=1 -> all outputs 0, busy=0. Then init_we with init_data=8'h53 -> q0=8'h53, q_valid=4'b0001.
- **Streaming:** start, then back-to-back results (8'hCA→1, 8'h1B→2, 8'hFF→3 with last=1), hold=0.
  - Each q updates one cycle after acceptance.
  - wr_cnt=3, done pulses once, q_valid=4'b1111.
- **Hold:** hold=1 for 3 cycles with a pending entry -> in_ready=0, q unchanged. Release -> write occurs next edge, in_ready returns to 1.
- **Overwrite:** two results to dest 2 (8'h10, then 8'h20) -> q2=8'h20, wr_cnt=2.
- **Last blocking:** in_valid held high after last accepted -> no further accept, in_ready=0 through DONE. After return to IDLE, start accepts again with wr_cnt reset to 0.
- **Saturation:** 300 non-last writes -> wr_cnt stops at 255.
